// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed active-low 7-segment bus: de-glitches each {digit, pattern}
// pair, decodes it to a hex nibble or dash, and hands out complete frames via valid/ready.
module seven_seg_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [6:0]            iSeg,
    input  logic [DIGITS-1:0]     iDig,
    output logic [4*DIGITS-1:0]   oNums,
    output logic [DIGITS-1:0]     oDash,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [7:0]            oErrCnt
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYC - 1);
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    // Returns {valid, dash, nibble}; dash reads as nibble 0.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h40:   r = {2'b10, 4'h0};
            7'h79:   r = {2'b10, 4'h1};
            7'h24:   r = {2'b10, 4'h2};
            7'h30:   r = {2'b10, 4'h3};
            7'h19:   r = {2'b10, 4'h4};
            7'h12:   r = {2'b10, 4'h5};
            7'h02:   r = {2'b10, 4'h6};
            7'h78:   r = {2'b10, 4'h7};
            7'h00:   r = {2'b10, 4'h8};
            7'h10:   r = {2'b10, 4'h9};
            7'h08:   r = {2'b10, 4'hA};
            7'h03:   r = {2'b10, 4'hB};
            7'h46:   r = {2'b10, 4'hC};
            7'h21:   r = {2'b10, 4'hD};
            7'h06:   r = {2'b10, 4'hE};
            7'h0E:   r = {2'b10, 4'hF};
            7'h3F:   r = {2'b11, 4'h0};
            default: r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [DIGITS-1:0] d);
        return (d != '0) && ((d & (d - DIGITS'(1))) == '0);
    endfunction

    logic [SW-1:0]          samp_q, samp_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0]    slot_q, slot_d;
    logic [DIGITS-1:0]      slot_dash_q, slot_dash_d;
    logic [DIGITS-1:0]      seen_q, seen_d;
    logic [4*DIGITS-1:0]    nums_q, nums_d;
    logic [DIGITS-1:0]      dash_q, dash_d;
    logic                   valid_q, valid_d;
    logic [7:0]             err_q, err_d;
    logic [0:0]             state_q, state_d;

    logic [SW-1:0]          in_s;
    logic                   match_s;
    logic                   event_s;
    logic [5:0]             dec_s;
    logic                   capture_s;
    logic                   error_s;
    logic [DIGITS-1:0]      cap_mask_s;

    assign in_s    = {iDig, iSeg};
    assign match_s = (in_s == samp_q);
    assign dec_s   = seg_decode(iSeg);

    // Stability filter: track the last sample and how long it has been held.
    always_comb begin
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        event_s = 1'b0;
        if (!match_s) begin
            samp_d = in_s;
            cnt_d  = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (STABLE_CYC == 1) begin
            event_s = 1'b1;
        end else begin
            event_s = match_s && (cnt_q == CNT_FIRE);
        end
    end

    // Classify stable events and update working slots and error count.
    always_comb begin
        capture_s   = event_s && is_onehot(iDig) && dec_s[5];
        error_s     = event_s && (iDig != '0) && !(is_onehot(iDig) && dec_s[5]);
        cap_mask_s  = capture_s ? iDig : '0;
        slot_d      = slot_q;
        slot_dash_d = slot_dash_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cap_mask_s[i]) begin
                slot_d[4*i +: 4] = dec_s[3:0];
                slot_dash_d[i]   = dec_s[4];
            end else begin
                slot_d[4*i +: 4] = slot_q[4*i +: 4];
                slot_dash_d[i]   = slot_dash_q[i];
            end
        end
        if (error_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Frame FSM: collect all digits, then hold the frame until it is accepted.
    always_comb begin
        state_d = state_q;
        nums_d  = nums_q;
        dash_d  = dash_q;
        valid_d = valid_q;
        seen_d  = seen_q | cap_mask_s;
        case (state_q)
            ST_COLLECT: begin
                if (seen_q == {DIGITS{1'b1}}) begin
                    nums_d  = slot_q;
                    dash_d  = slot_dash_q;
                    valid_d = 1'b1;
                    seen_d  = cap_mask_s;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (iReady) begin
                    valid_d = 1'b0;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            samp_q      <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            slot_dash_q <= '0;
            seen_q      <= '0;
            nums_q      <= '0;
            dash_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 8'd0;
            state_q     <= ST_COLLECT;
        end else begin
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            slot_dash_q <= slot_dash_d;
            seen_q      <= seen_d;
            nums_q      <= nums_d;
            dash_q      <= dash_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    assign oNums   = nums_q;
    assign oDash   = dash_q;
    assign oValid  = valid_q;
    assign oErrCnt = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: expected frames are queued as stimulus is
// driven and compared when oValid rises.
module tb_seven_seg_reader;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [6:0]  iSeg;
    logic [3:0]  iDig;
    logic [15:0] oNums;
    logic [3:0]  oDash;
    logic        oValid;
    logic        iReady;
    logic [7:0]  oErrCnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q[$];
    logic        prev_valid = 1'b0;

    seven_seg_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iSeg    (iSeg),
        .iDig    (iDig),
        .oNums   (oNums),
        .oDash   (oDash),
        .oValid  (oValid),
        .iReady  (iReady),
        .oErrCnt (oErrCnt)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare each new frame against the oldest expected one.
    always @(negedge iClk) begin
        if (iRst_n && oValid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("frame_nums", {16'd0, oNums}, {16'd0, e[15:0]});
                check("frame_dash", {28'd0, oDash}, {28'd0, e[19:16]});
            end
        end
        prev_valid <= oValid;
    end

    task automatic send(input logic [3:0] dig, input logic [6:0] seg, input int cycles);
        @(negedge iClk);
        iDig = dig;
        iSeg = seg;
        repeat (cycles) @(posedge iClk);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge iClk);
        while (!oValid && n < 20) begin
            @(negedge iClk);
            n++;
        end
        check(tag, {31'd0, oValid}, 32'd1);
    endtask

    task automatic accept();
        wait_valid("accept_valid");
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iReady = 1'b0;
        check("accept_drop", {31'd0, oValid}, 32'd0);
    endtask

    initial begin
        iRst_n = 1'b0;
        iReady = 1'b0;
        iDig   = 4'd0;
        iSeg   = 7'h7F;
        repeat (3) @(negedge iClk);
        check("rst_nums",  {16'd0, oNums},  32'd0);
        check("rst_dash",  {28'd0, oDash},  32'd0);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_err",   {24'd0, oErrCnt}, 32'd0);
        iRst_n = 1'b1;

        // Basic frame and capture-to-valid latency
        exp_q.push_back({4'b0000, 16'h4321});
        send(4'b0001, 7'h79, 4);
        send(4'b0010, 7'h24, 4);
        send(4'b0100, 7'h30, 4);
        send(4'b1000, 7'h19, 4);
        @(negedge iClk);
        check("lat_pre", {31'd0, oValid}, 32'd0);
        @(negedge iClk);
        check("lat_post", {31'd0, oValid}, 32'd1);
        check("t1_err", {24'd0, oErrCnt}, 32'd0);
        accept();

        // Glitch rejected; long hold yields one capture
        exp_q.push_back({4'b0000, 16'h7530});
        send(4'b0010, 7'h24, 3);
        send(4'b0010, 7'h30, 4);
        send(4'b0001, 7'h40, 4);
        send(4'b0100, 7'h12, 4);
        send(4'b1000, 7'h78, 10);
        accept();

        // Invalid events: blank pattern and multi-hot strobe
        send(4'b0001, 7'h40, 4);
        send(4'b0010, 7'h79, 4);
        send(4'b1000, 7'h19, 4);
        send(4'b0100, 7'h7F, 10);
        send(4'b0011, 7'h79, 5);
        check("t3_err", {24'd0, oErrCnt}, 32'd2);
        @(negedge iClk);
        check("t3_noframe", {31'd0, oValid}, 32'd0);
        exp_q.push_back({4'b0000, 16'h4210});
        send(4'b0100, 7'h24, 4);
        wait_valid("t3_valid");

        // Backpressure: frame frozen while new captures land
        send(4'b0001, 7'h08, 4);
        send(4'b0010, 7'h03, 4);
        send(4'b0100, 7'h46, 4);
        send(4'b1000, 7'h21, 4);
        @(negedge iClk);
        check("hold_nums",  {16'd0, oNums}, 32'h4210);
        check("hold_valid", {31'd0, oValid}, 32'd1);
        exp_q.push_back({4'b0000, 16'hDCBA});
        accept();
        @(negedge iClk);
        check("reload_valid", {31'd0, oValid}, 32'd1);
        accept();

        // Dash decode, then error counter saturation
        exp_q.push_back({4'b1000, 16'h0000});
        send(4'b0001, 7'h40, 4);
        send(4'b0010, 7'h40, 4);
        send(4'b0100, 7'h40, 4);
        send(4'b1000, 7'h3F, 4);
        accept();
        for (int i = 0; i < 300; i++) begin
            send(4'b0001, (i % 2 == 1) ? 7'h7F : 7'h7E, 4);
        end
        @(negedge iClk);
        check("err_sat", {24'd0, oErrCnt}, 32'd255);

        // Asynchronous reset with a held frame and a partial mask
        exp_q.push_back({4'b0000, 16'h3210});
        send(4'b0001, 7'h40, 4);
        send(4'b0010, 7'h79, 4);
        send(4'b0100, 7'h24, 4);
        send(4'b1000, 7'h30, 4);
        wait_valid("t6_valid");
        send(4'b0001, 7'h19, 4);
        #2;
        iRst_n = 1'b0;
        #1;
        check("arst_nums",  {16'd0, oNums},  32'd0);
        check("arst_dash",  {28'd0, oDash},  32'd0);
        check("arst_valid", {31'd0, oValid}, 32'd0);
        check("arst_err",   {24'd0, oErrCnt}, 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        send(4'b0010, 7'h02, 4);
        send(4'b0100, 7'h78, 4);
        send(4'b1000, 7'h00, 4);
        @(negedge iClk);
        @(negedge iClk);
        check("arst_partial", {31'd0, oValid}, 32'd0);
        exp_q.push_back({4'b0000, 16'h8765});
        send(4'b0001, 7'h12, 4);
        accept();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
